// File: rtl/lvt_write_resolver.sv
// rtl/lvt_write_resolver.sv - write-port front end for the 2W/4R LVT register file
// Registers two write requests, drops the older one on a same-address clash, and runs an init sweep after reset.
module lvt_write_resolver #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] waddr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] waddr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  we0,
  output logic [ADDR_WIDTH-1:0] write_addr_0,
  output logic [DATA_WIDTH-1:0] write_data_0,
  output logic                  we1,
  output logic [ADDR_WIDTH-1:0] write_addr_1,
  output logic [DATA_WIDTH-1:0] write_data_1,
  output logic                  conflict_o,
  output logic                  busy_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Highest even address: the last pair of the sweep is (DEPTH-2, DEPTH-1).
  localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ADDR_WIDTH-1:0] PAIR_STEP = ADDR_WIDTH'(2);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] counter_next;
  logic [ADDR_WIDTH-1:0] counter_odd;

  logic                  run_conflict;
  logic                  we0_next;
  logic [ADDR_WIDTH-1:0] write_addr_0_next;
  logic [DATA_WIDTH-1:0] write_data_0_next;
  logic                  we1_next;
  logic [ADDR_WIDTH-1:0] write_addr_1_next;
  logic [DATA_WIDTH-1:0] write_data_1_next;
  logic                  conflict_next;

  // Counter is always even, so counter+1 is just the low bit set.
  assign counter_odd  = {counter[ADDR_WIDTH-1:1], 1'b1};
  assign run_conflict = we0_i & we1_i & (waddr0_i == waddr1_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_INIT;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    if (state == ST_INIT) begin
      counter_next = counter + PAIR_STEP;
      if (counter == LAST_PAIR) begin
        state_next = ST_RUN;
      end
    end
  end

  always_comb begin
    we0_next          = 1'b0;
    write_addr_0_next = '0;
    write_data_0_next = '0;
    we1_next          = 1'b0;
    write_addr_1_next = '0;
    write_data_1_next = '0;
    conflict_next     = 1'b0;
    if (state == ST_INIT) begin
      we0_next          = 1'b1;
      write_addr_0_next = counter;
      write_data_0_next = INIT_VALUE;
      we1_next          = 1'b1;
      write_addr_1_next = counter_odd;
      write_data_1_next = INIT_VALUE;
    end else begin
      // Port 1 is the younger write; on a clash port 0 is suppressed.
      we0_next          = we0_i & ~run_conflict;
      write_addr_0_next = waddr0_i;
      write_data_0_next = wdata0_i;
      we1_next          = we1_i;
      write_addr_1_next = waddr1_i;
      write_data_1_next = wdata1_i;
      conflict_next     = run_conflict;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we0          <= 1'b0;
      write_addr_0 <= '0;
      write_data_0 <= '0;
      we1          <= 1'b0;
      write_addr_1 <= '0;
      write_data_1 <= '0;
      conflict_o   <= 1'b0;
    end else begin
      we0          <= we0_next;
      write_addr_0 <= write_addr_0_next;
      write_data_0 <= write_data_0_next;
      we1          <= we1_next;
      write_addr_1 <= write_addr_1_next;
      write_data_1 <= write_data_1_next;
      conflict_o   <= conflict_next;
    end
  end

  assign busy_o = (state == ST_INIT);

endmodule

// File: tb/tb_lvt_write_resolver.sv
// tb/tb_lvt_write_resolver.sv - directed bench for lvt_write_resolver
// Linear directed steps; outputs sampled 1 time unit after each rising edge.
module tb_lvt_write_resolver;

  logic        clock;
  logic        reset;
  logic        we0_i;
  logic [3:0]  waddr0_i;
  logic [31:0] wdata0_i;
  logic        we1_i;
  logic [3:0]  waddr1_i;
  logic [31:0] wdata1_i;
  logic        we0;
  logic [3:0]  write_addr_0;
  logic [31:0] write_data_0;
  logic        we1;
  logic [3:0]  write_addr_1;
  logic [31:0] write_data_1;
  logic        conflict_o;
  logic        busy_o;

  int tests_run;
  int tests_failed;

  lvt_write_resolver #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32),
    .INIT_VALUE(32'h0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .we0_i       (we0_i),
    .waddr0_i    (waddr0_i),
    .wdata0_i    (wdata0_i),
    .we1_i       (we1_i),
    .waddr1_i    (waddr1_i),
    .wdata1_i    (wdata1_i),
    .we0         (we0),
    .write_addr_0(write_addr_0),
    .write_data_0(write_data_0),
    .we1         (we1),
    .write_addr_1(write_addr_1),
    .write_data_1(write_data_1),
    .conflict_o  (conflict_o),
    .busy_o      (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    we0_i    = 1'b0;
    waddr0_i = 4'h0;
    wdata0_i = 32'h0;
    we1_i    = 1'b0;
    waddr1_i = 4'h0;
    wdata1_i = 32'h0;
  endtask

  // Runs sweep steps; injects a port-0 request before step inject_at and
  // asserts reset before step reset_at (then stops, leaving reset low again).
  task automatic run_sweep(input int inject_at, input int reset_at, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i == inject_at) begin
        we0_i    = 1'b1;
        waddr0_i = 4'd9;
        wdata0_i = 32'hBAD0BAD0;
      end
      if (i == reset_at) begin
        reset = 1'b1;
        tick();
        chk({tag, "_rst_we0"}, 32'(we0), 32'd0);
        chk({tag, "_rst_we1"}, 32'(we1), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy_o), 32'd1);
        reset = 1'b0;
        return;
      end
      tick();
      idle_inputs();
      chk($sformatf("%s_we0_%0d", tag, i), 32'(we0), 32'd1);
      chk($sformatf("%s_we1_%0d", tag, i), 32'(we1), 32'd1);
      chk($sformatf("%s_a0_%0d", tag, i), 32'(write_addr_0), 32'(2 * i));
      chk($sformatf("%s_a1_%0d", tag, i), 32'(write_addr_1), 32'(2 * i + 1));
      chk($sformatf("%s_d0_%0d", tag, i), write_data_0, 32'h0);
      chk($sformatf("%s_d1_%0d", tag, i), write_data_1, 32'h0);
      chk($sformatf("%s_cf_%0d", tag, i), 32'(conflict_o), 32'd0);
      chk($sformatf("%s_busy_%0d", tag, i), 32'(busy_o), (i < 7) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("reset_we0", 32'(we0), 32'd0);
    chk("reset_we1", 32'(we1), 32'd0);
    chk("reset_cf", 32'(conflict_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd1);
    chk("reset_a0", 32'(write_addr_0), 32'd0);
    chk("reset_d1", write_data_1, 32'd0);
    reset = 1'b0;

    // First sweep with an ignored request in the 3rd sweep cycle
    run_sweep(2, -1, "sweep1");

    // Independent writes
    we0_i = 1'b1; waddr0_i = 4'd3; wdata0_i = 32'hA5A5A5A5;
    we1_i = 1'b1; waddr1_i = 4'd7; wdata1_i = 32'h12345678;
    tick();
    chk("ind_we0", 32'(we0), 32'd1);
    chk("ind_a0", 32'(write_addr_0), 32'd3);
    chk("ind_d0", write_data_0, 32'hA5A5A5A5);
    chk("ind_we1", 32'(we1), 32'd1);
    chk("ind_a1", 32'(write_addr_1), 32'd7);
    chk("ind_d1", write_data_1, 32'h12345678);
    chk("ind_cf", 32'(conflict_o), 32'd0);
    chk("ind_busy", 32'(busy_o), 32'd0);

    // Same-address conflict
    we0_i = 1'b1; waddr0_i = 4'd5; wdata0_i = 32'h11;
    we1_i = 1'b1; waddr1_i = 4'd5; wdata1_i = 32'h22;
    tick();
    chk("cf_we0", 32'(we0), 32'd0);
    chk("cf_we1", 32'(we1), 32'd1);
    chk("cf_a1", 32'(write_addr_1), 32'd5);
    chk("cf_d1", write_data_1, 32'h22);
    chk("cf_flag", 32'(conflict_o), 32'd1);
    idle_inputs();
    tick();
    chk("cf_pulse_end", 32'(conflict_o), 32'd0);
    chk("idle_we0", 32'(we0), 32'd0);
    chk("idle_we1", 32'(we1), 32'd0);

    // Same address but port 1 idle: no conflict, port 0 passes
    we0_i = 1'b1; waddr0_i = 4'd5; wdata0_i = 32'h33;
    we1_i = 1'b0; waddr1_i = 4'd5; wdata1_i = 32'h44;
    tick();
    chk("p0only_we0", 32'(we0), 32'd1);
    chk("p0only_d0", write_data_0, 32'h33);
    chk("p0only_we1", 32'(we1), 32'd0);
    chk("p0only_cf", 32'(conflict_o), 32'd0);

    // Addresses differing only in the top bit
    we0_i = 1'b1; waddr0_i = 4'd2;  wdata0_i = 32'hCAFE0002;
    we1_i = 1'b1; waddr1_i = 4'd10; wdata1_i = 32'hCAFE000A;
    tick();
    chk("near_we0", 32'(we0), 32'd1);
    chk("near_a0", 32'(write_addr_0), 32'd2);
    chk("near_a1", 32'(write_addr_1), 32'd10);
    chk("near_cf", 32'(conflict_o), 32'd0);
    idle_inputs();

    // Mid-sweep reset, then a full restarted sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_sweep(-1, 4, "midrst");
    run_sweep(-1, -1, "sweep2");

    // Reset in RUN with a valid request pending
    we0_i = 1'b1; waddr0_i = 4'd3; wdata0_i = 32'hDEADBEEF;
    we1_i = 1'b1; waddr1_i = 4'd4; wdata1_i = 32'hFEEDFACE;
    reset = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    chk("runrst_we0", 32'(we0), 32'd0);
    chk("runrst_we1", 32'(we1), 32'd0);
    chk("runrst_busy", 32'(busy_o), 32'd1);
    run_sweep(-1, -1, "sweep3");

    tick();
    chk("final_we0", 32'(we0), 32'd0);
    chk("final_we1", 32'(we1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
